// File: rtl/histogram_accumulator.sv
// Streaming histogram front end: read-increment-write on RAM port A, with forwarding so repeated bins count correctly.
// Latency: pixel sampled at edge n -> read request n+1, write n+3, frame_done in cycle n+4 after the last pixel.
// Backpressure: none; one pixel per clock, and pixels offered while unarmed or after a full frame are dropped.
module histogram_accumulator #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int COLOR_RANGE  = 256,
    localparam int TOTAL_PIXEL   = IMAGE_WIDTH * IMAGE_HEIGHT,
    // Bit counts needed to hold TOTAL_PIXEL-1, COLOR_RANGE-1 and TOTAL_PIXEL respectively
    localparam int DATA_WIDTH    = $clog2(TOTAL_PIXEL),
    localparam int ADDRESS_WIDTH = $clog2(COLOR_RANGE),
    localparam int CNT_WIDTH     = $clog2(TOTAL_PIXEL + 1)
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     frame_start,
    input  logic                     pixel_valid,
    input  logic [PIXEL_WIDTH-1:0]   pixel_data,
    output logic [ADDRESS_WIDTH-1:0] read_addr_A,
    output logic                     rvalid_A,
    input  logic [DATA_WIDTH-1:0]    read_data_A,
    input  logic                     dvalid_A,
    output logic [ADDRESS_WIDTH-1:0] write_addr_A,
    output logic [DATA_WIDTH-1:0]    write_data_A,
    output logic                     wvalid_A,
    output logic                     frame_done,
    output logic                     busy,
    output logic                     rd_miss
);

    localparam logic [CNT_WIDTH-1:0] FRAME_PIXELS = CNT_WIDTH'(TOTAL_PIXEL);

    logic [ADDRESS_WIDTH-1:0] pix_bin;
    assign pix_bin = pixel_data[ADDRESS_WIDTH-1:0];

    // Pixel bits above the bin address do not select a bin
    generate
        if (PIXEL_WIDTH > ADDRESS_WIDTH) begin : g_hi_bits
            logic unused_hi;
            assign unused_hi = ^pixel_data[PIXEL_WIDTH-1:ADDRESS_WIDTH];
        end
    endgenerate

    logic [CNT_WIDTH-1:0]     pix_cnt_q, pix_cnt_d;
    logic                     armed_q, armed_d;
    logic                     s1_vld_q, s1_vld_d;
    logic [ADDRESS_WIDTH-1:0] s1_bin_q, s1_bin_d;
    logic                     s2_vld_q, s2_vld_d;
    logic [ADDRESS_WIDTH-1:0] s2_bin_q, s2_bin_d;
    logic                     s3_vld_q, s3_vld_d;
    logic [ADDRESS_WIDTH-1:0] s3_bin_q, s3_bin_d;
    logic [DATA_WIDTH-1:0]    s3_dat_q, s3_dat_d;
    logic                     s4_vld_q, s4_vld_d;
    logic [ADDRESS_WIDTH-1:0] s4_bin_q, s4_bin_d;
    logic [DATA_WIDTH-1:0]    s4_dat_q, s4_dat_d;
    logic                     rd_miss_q, rd_miss_d;

    logic                     accept;
    logic                     done;
    logic [DATA_WIDTH-1:0]    base;
    logic [DATA_WIDTH-1:0]    next_cnt;

    // Frame accounting: acceptance, pixel count, arm/disarm, sticky read-miss flag
    always_comb begin
        // frame_start makes a same-cycle pixel pixel 0 of the new frame
        accept = pixel_valid && (frame_start || (armed_q && (pix_cnt_q < FRAME_PIXELS)));
        done   = armed_q && (pix_cnt_q == FRAME_PIXELS) && !s1_vld_q && !s2_vld_q && !s3_vld_q;

        pix_cnt_d = frame_start ? '0 : pix_cnt_q;
        if (accept) begin
            pix_cnt_d = pix_cnt_d + CNT_WIDTH'(1);
        end

        armed_d = armed_q;
        if (done) begin
            armed_d = 1'b0;
        end
        if (frame_start) begin
            armed_d = 1'b1;
        end

        rd_miss_d = (frame_start ? 1'b0 : rd_miss_q) | (s2_vld_q & ~dvalid_A);
    end

    // Pipeline advance with forwarding of counts not yet visible in the RAM read
    always_comb begin
        s1_vld_d = accept;
        s1_bin_d = accept ? pix_bin : s1_bin_q;
        s2_vld_d = s1_vld_q;
        s2_bin_d = s1_bin_q;

        // S3 holds the write committing this cycle; S4 the one that committed on the read edge
        if (s3_vld_q && (s3_bin_q == s2_bin_q)) begin
            base = s3_dat_q;
        end else if (s4_vld_q && (s4_bin_q == s2_bin_q)) begin
            base = s4_dat_q;
        end else begin
            base = read_data_A;
        end
        next_cnt = (&base) ? base : base + DATA_WIDTH'(1);

        s3_vld_d = s2_vld_q;
        s3_bin_d = s2_bin_q;
        s3_dat_d = s2_vld_q ? next_cnt : s3_dat_q;
        s4_vld_d = s3_vld_q;
        s4_bin_d = s3_bin_q;
        s4_dat_d = s3_dat_q;
    end

    // State registers; reset drops in-flight increments without touching the RAM
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pix_cnt_q <= '0;
            armed_q   <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_bin_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_bin_q  <= '0;
            s3_vld_q  <= 1'b0;
            s3_bin_q  <= '0;
            s3_dat_q  <= '0;
            s4_vld_q  <= 1'b0;
            s4_bin_q  <= '0;
            s4_dat_q  <= '0;
            rd_miss_q <= 1'b0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            armed_q   <= armed_d;
            s1_vld_q  <= s1_vld_d;
            s1_bin_q  <= s1_bin_d;
            s2_vld_q  <= s2_vld_d;
            s2_bin_q  <= s2_bin_d;
            s3_vld_q  <= s3_vld_d;
            s3_bin_q  <= s3_bin_d;
            s3_dat_q  <= s3_dat_d;
            s4_vld_q  <= s4_vld_d;
            s4_bin_q  <= s4_bin_d;
            s4_dat_q  <= s4_dat_d;
            rd_miss_q <= rd_miss_d;
        end
    end

    assign read_addr_A  = s1_bin_q;
    assign rvalid_A     = s1_vld_q;
    assign write_addr_A = s3_bin_q;
    assign write_data_A = s3_dat_q;
    assign wvalid_A     = s3_vld_q;
    assign frame_done   = done;
    assign busy         = s1_vld_q || s2_vld_q || s3_vld_q || (armed_q && (pix_cnt_q < FRAME_PIXELS));
    assign rd_miss      = rd_miss_q;

endmodule

// File: doc/histogram_accumulator.md
# histogram_accumulator

Streaming front end of the histogram path: accepts one pixel per clock, performs a read-increment-write on the histogram RAM's read port A and write port A, and forwards in-flight counts so back-to-back equal pixels accumulate correctly. Tracks pixels per frame and pulses `frame_done` once the last write of the frame has committed. Read-out and clearing happen downstream on RAM port B and are outside this block.

## Interface
- `PIXEL_WIDTH`, 8, pixel bits; bin address is the low `ADDRESS_WIDTH` bits of the pixel.
- `IMAGE_WIDTH`, 640, pixels per line.
- `IMAGE_HEIGHT`, 480, lines per frame.
- `COLOR_RANGE`, 256, number of bins.
- Derived: `TOTAL_PIXEL` = W*H. `DATA_WIDTH` = clogb2(`TOTAL_PIXEL`-1). `ADDRESS_WIDTH` = clogb2(`COLOR_RANGE`-1). `CNT_WIDTH` = clogb2(`TOTAL_PIXEL`).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `arst`  in  1  asynchronous reset, active-high.
- `frame_start`  in  1  one-cycle pulse that restarts the frame pixel count.
- `pixel_valid`  in  1  `pixel_data` is valid this cycle.
- `pixel_data`  in  `PIXEL_WIDTH`  pixel value.
- `read_addr_A`  out  `ADDRESS_WIDTH`  RAM port A read address.
- `rvalid_A`  out  1  RAM port A read request.
- `read_data_A`  in  `DATA_WIDTH`  RAM read data, one cycle after the request.
- `dvalid_A`  in  1  RAM read-data valid.
- `write_addr_A`  out  `ADDRESS_WIDTH`  RAM write address.
- `write_data_A`  out  `DATA_WIDTH`  RAM write data.
- `wvalid_A`  out  1  RAM write enable.
- `frame_done`  out  1  one-cycle pulse after the frame's last write has committed.
- `busy`  out  1  a pixel is in flight (S1–S3 valid) or the frame is incomplete.
- `rd_miss`  out  1  sticky: S2 valid while `dvalid_A` low. Cleared by `arst` or `frame_start`.

## Operation
- Frame counter `pix_cnt` (`CNT_WIDTH`):
  - `frame_start` sets it to 0 and sets `armed`=1.
  - A pixel is accepted when `pixel_valid` && `armed` && `pix_cnt` < `TOTAL_PIXEL`. Each accepted pixel increments `pix_cnt`.
  - Pixels offered when not accepted are dropped silently.
  - `frame_start` together with `pixel_valid` in the same cycle: the pixel counts as pixel 0 of the new frame.
- Pipeline (valid bit plus bin per stage):
  - S1: registered accepted pixel. Drives `read_addr_A`/`rvalid_A` directly from S1 registers.
  - S2: S1 advanced. The RAM data for this bin arrives now. `base` is selected by priority:
    - S3 bin equal → S3 data;
    - else S4 bin equal → S4 data;
    - else `read_data_A`.
  - `next` = `base`+1, saturating at all-ones of `DATA_WIDTH`.
  - S3: registered S2 bin/`next`/valid. Drives `write_addr_A`/`write_data_A`/`wvalid_A`. The RAM commits at the end of this cycle.
  - S4: copy of S3 (bin, data, valid), used only for forwarding. It covers the write that commits on the same edge as S2's RAM read.
- Forwarding compares only valid stages.
- `frame_start` mid-frame does not flush the pipeline. In-flight pixels still write, and a `frame_done` for the abandoned frame is suppressed.
- `frame_done` fires when `pix_cnt` = `TOTAL_PIXEL`, `armed`=1, and S1–S3 are all invalid. `armed` is then cleared, so the pulse occurs once per frame.
- `arst` mid-frame: all pipeline valids, `pix_cnt`, `armed` and `rd_miss` go to 0. In-flight increments are lost; RAM contents are not touched.

## Timing
- Reset values: `read_addr_A`, `rvalid_A`, `write_addr_A`, `write_data_A`, `wvalid_A`, `frame_done`, `busy` and `rd_miss` are all 0.
- Pixel sampled at the edge ending cycle n:
  - `rvalid_A` high in cycle n+1;
  - read data used in cycle n+2;
  - `wvalid_A` high in cycle n+3, RAM updated at the end of n+3.
- Throughput is one pixel per clock with no stalls and no backpressure.
- Last pixel sampled at the end of cycle n → `frame_done` high in cycle n+4 exactly.
- `busy` falls in the same cycle that `frame_done` rises.

## Test plan
- Parameters W=4, H=2, `COLOR_RANGE`=16 (`TOTAL_PIXEL`=8, `DATA_WIDTH`=3), with a behavioural 1-cycle-read RAM model.
- Pixels 0..7 back-to-back after `frame_start` → bins 0–7 = 1, others 0. `frame_done` exactly 4 cycles after the last pixel, once.
- Eight consecutive pixels = 5 → bin 5 = 7 (saturated, not wrapped). Writes seen with values 1,2,…,7,7.
- Pattern 3,9,3,9,3,3,9,3 contiguous → bin 3 = 5, bin 9 = 3. Exercises S3 and S4 forwarding.
- Same 8 pixels with gaps of 1 and 2 idle cycles between them → identical counts. A 9th pixel before the next `frame_start` → dropped, no RAM write.
- `arst` pulsed after 3 pixels, then `frame_start` + 8 pixels → no `frame_done` before reset, exactly one after. `dvalid_A` forced low once → `rd_miss`=1 until the next `frame_start`.
